gate_deadtime_sequencer: RTL and testbench
==========================================

GATE_DEADTIME_SEQUENCER -- requirements
Module: gate_deadtime_sequencer

Interface
REQ-001 Parameter DEADTIME, default 32'd10: dead-time length in i_clock cycles with both gates of a leg off; legal range 1..65535.
REQ-002 Parameter MIN_ON, default 32'd20: minimum on-dwell in cycles before a conducting gate may turn off for commutation; legal range 1..65535.
REQ-003 i_clock  input  1  system clock; all logic on its rising edge.
REQ-004 i_RESET  input  1  reset, synchronous, active-high.
REQ-005 i_MOSFET  input  4  raw gate command from the hybrid controller; leg A = bits {0 high-side, 2 low-side}, leg B = bits {1 high-side, 3 low-side}.
REQ-006 i_enable  input  1  1 = gating allowed; 0 = force all gates off.
REQ-007 i_fault  input  1  external trip, active-high.
REQ-008 i_fault_clear  input  1  one-cycle pulse that clears the latched fault.
REQ-009 o_gate  output  4  dead-time-safe gate drive, same bit mapping as i_MOSFET, registered.
REQ-010 o_leg_state  output  4  [1:0] leg A state, [3:2] leg B state (encoding REQ-014).
REQ-011 o_fault  output  1  latched fault flag, registered.
REQ-012 o_busy  output  1  1 while either leg is in DEAD.

Function
REQ-013 Per-leg command decode per cycle: hi&~lo = CMD_H; ~hi&lo = CMD_L; ~hi&~lo = CMD_OFF; hi&lo = illegal.
REQ-014 Per-leg FSM states: OFF=2'b00, ON_H=2'b01, ON_L=2'b10, DEAD=2'b11; a 16-bit unsigned counter per leg counts cycles in the current state and saturates at 16'hFFFF.
REQ-015 The counter clears to 0 on every state entry and increments by 1 each cycle the state is held.
REQ-016 ON_H or ON_L with the opposite command and counter >= MIN_ON-1 -> DEAD on the next edge; with counter < MIN_ON-1 the state is held.
REQ-017 ON_H or ON_L with CMD_OFF -> OFF on the next edge, ignoring MIN_ON, because turn-off is always safe.
REQ-018 DEAD with counter = DEADTIME-1 -> ON_H, ON_L or OFF according to the command sampled in that cycle; otherwise hold DEAD.
REQ-019 OFF with CMD_H or CMD_L -> DEAD; entry from OFF always passes through a full dead time.
REQ-020 Gate outputs: ON_H drives the high-side bit only, ON_L the low-side bit only, OFF and DEAD drive both bits 0; a leg never drives both bits 1.
REQ-021 Latency: a command change sampled at edge k gives a DEAD entry and old-gate deassert at edge k+1, and a new-gate assert at edge k+1+DEADTIME, provided MIN_ON is already met.
REQ-022 Fault set: i_fault=1, or an illegal pair on either leg -> o_fault=1, both legs OFF and o_gate=4'b0000 at the next edge.
REQ-023 While o_fault=1 the legs stay OFF regardless of commands.
REQ-024 i_fault_clear clears o_fault only when i_fault=0 in the same cycle; when a fault condition and the clear occur together, the fault wins.
REQ-025 i_enable=0 -> both legs OFF at the next edge; o_fault is unaffected.
REQ-026 After re-enable, a leg leaving OFF obeys REQ-019.
REQ-027 Legs A and B are independent; simultaneous commutation of both legs is allowed.
REQ-028 o_busy = (leg A state == DEAD) | (leg B state == DEAD), decoded from registered state.

Reset
REQ-029 At an i_RESET=1 edge: both legs OFF, counters 0, o_gate=4'b0000, o_leg_state=4'b0000, o_fault=0, o_busy=0.
REQ-030 Reset has priority over fault, enable and command inputs; reset mid-DEAD or mid-ON aborts immediately with no dead-time completion.

Structure
REQ-031 A shared package holds the leg-state encodings (OFF/ON_H/ON_L/DEAD), the command decode codes and the counter width constant (16).
REQ-032 Sub-module gate_leg_fsm (one leg: decode, FSM, counter, two gate outputs) is instantiated twice; the top holds the fault latch, the enable gating and the o_busy OR.

Verification
REQ-033 Defaults; leg A held CMD_H for 30 cycles, then CMD_L at edge k -> o_gate[0] falls at k+1, o_gate[2] rises at k+11, o_busy high for exactly 10 cycles.
REQ-034 Leg A enters ON_H; CMD_L is applied 5 cycles later -> state holds ON_H until counter=19, then 10 cycles of DEAD, then ON_L.
REQ-035 i_MOSFET=4'b0101 (leg A illegal) -> o_fault=1 and o_gate=0 at the next edge; i_fault_clear while i_fault=1 -> o_fault stays 1; clear with i_fault=0 -> o_fault=0 and the legs re-enter via DEAD.
REQ-036 i_enable dropped while leg B is in ON_L -> o_gate[3]=0 at the next edge; re-enable with CMD_H -> o_gate[1] asserts 11 edges later.
REQ-037 i_RESET pulsed during DEAD -> all outputs 0 at that edge; with no command present after release, the state stays OFF.
REQ-038 Drive the 4-state hybrid-control cycle (b1b0 = 00,01,10,11 repeating, 40 cycles each) -> at no cycle is o_gate[0]&o_gate[2] or o_gate[1]&o_gate[3] true, and every gate edge is preceded by >= 10 dead cycles.

Source files
------------

// File: rtl/gate_deadtime_sequencer_pkg.sv
// Shared definitions for the gate dead-time sequencer: leg-state encoding,
// per-leg command codes, counter width and the command decode helper.
package gate_deadtime_sequencer_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        LEG_OFF  = 2'b00,
        LEG_ON_H = 2'b01,
        LEG_ON_L = 2'b10,
        LEG_DEAD = 2'b11
    } leg_state_e;

    typedef enum logic [1:0] {
        CMD_OFF     = 2'b00,
        CMD_H       = 2'b01,
        CMD_L       = 2'b10,
        CMD_ILLEGAL = 2'b11
    } leg_cmd_e;

    // Turns a raw high/low gate request pair into a leg command.
    function automatic leg_cmd_e decode_cmd(input logic hi, input logic lo);
        leg_cmd_e cmd;
        case ({hi, lo})
            2'b10:   cmd = CMD_H;
            2'b01:   cmd = CMD_L;
            2'b00:   cmd = CMD_OFF;
            default: cmd = CMD_ILLEGAL;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/gate_deadtime_sequencer_leg_fsm.sv
// One half-bridge leg: decodes its command pair, sequences OFF/ON_H/ON_L/DEAD
// with a saturating dwell counter and drives registered high/low gate bits.
// Both gate bits are derived from the next state, so they can never be 1
// together and they change on the same edge as the state.
module gate_leg_fsm
    import gate_deadtime_sequencer_pkg::*;
#(
    parameter logic [31:0] DEADTIME = 32'd10,
    parameter logic [31:0] MIN_ON   = 32'd20
) (
    input  logic       i_clock,
    input  logic       i_RESET,
    input  logic       i_hi,
    input  logic       i_lo,
    input  logic       i_force_off,
    output logic       o_gate_hi,
    output logic       o_gate_lo,
    output leg_state_e o_state,
    output logic       o_illegal
);

    localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'(DEADTIME - 32'd1);
    localparam logic [CNT_W-1:0] MIN_ON_M1  = CNT_W'(MIN_ON - 32'd1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    leg_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gate_hi_q, gate_hi_d;
    logic             gate_lo_q, gate_lo_d;
    leg_cmd_e         cmd;

    // Next-state, dwell counter and gate decode for this leg.
    always_comb begin
        cmd     = decode_cmd(i_hi, i_lo);
        state_d = state_q;
        if (i_force_off) begin
            state_d = LEG_OFF;
        end else begin
            unique case (state_q)
                LEG_OFF: begin
                    // Any turn-on always goes through a full dead time first.
                    if (cmd == CMD_H || cmd == CMD_L) state_d = LEG_DEAD;
                end
                LEG_ON_H: begin
                    if (cmd == CMD_OFF) state_d = LEG_OFF;
                    else if (cmd == CMD_L && cnt_q >= MIN_ON_M1) state_d = LEG_DEAD;
                end
                LEG_ON_L: begin
                    if (cmd == CMD_OFF) state_d = LEG_OFF;
                    else if (cmd == CMD_H && cnt_q >= MIN_ON_M1) state_d = LEG_DEAD;
                end
                LEG_DEAD: begin
                    if (cnt_q == DEAD_LAST) begin
                        if (cmd == CMD_H)      state_d = LEG_ON_H;
                        else if (cmd == CMD_L) state_d = LEG_ON_L;
                        else                   state_d = LEG_OFF;
                    end
                end
                default: state_d = LEG_OFF;
            endcase
        end

        if (state_d != state_q)   cnt_d = '0;
        else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
        else                       cnt_d = cnt_q + 1'b1;

        gate_hi_d = (state_d == LEG_ON_H);
        gate_lo_d = (state_d == LEG_ON_L);
    end

    // State, counter and gate registers with synchronous reset.
    always_ff @(posedge i_clock) begin
        if (i_RESET) begin
            state_q   <= LEG_OFF;
            cnt_q     <= '0;
            gate_hi_q <= 1'b0;
            gate_lo_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gate_hi_q <= gate_hi_d;
            gate_lo_q <= gate_lo_d;
        end
    end

    assign o_gate_hi = gate_hi_q;
    assign o_gate_lo = gate_lo_q;
    assign o_state   = state_q;
    assign o_illegal = (cmd == CMD_ILLEGAL);

endmodule

// File: rtl/gate_deadtime_sequencer.sv
// Two-leg dead-time sequencer: a leg FSM per half bridge plus the shared
// fault latch, enable gating and busy flag.
module gate_deadtime_sequencer
    import gate_deadtime_sequencer_pkg::*;
#(
    parameter logic [31:0] DEADTIME = 32'd10,
    parameter logic [31:0] MIN_ON   = 32'd20
) (
    input  logic       i_clock,
    input  logic       i_RESET,
    input  logic [3:0] i_MOSFET,
    input  logic       i_enable,
    input  logic       i_fault,
    input  logic       i_fault_clear,
    output logic [3:0] o_gate,
    output logic [3:0] o_leg_state,
    output logic       o_fault,
    output logic       o_busy
);

    logic       fault_q, fault_d;
    logic       fault_set;
    logic       force_off;
    logic       illegal_a, illegal_b;
    logic       hi_a, lo_a, hi_b, lo_b;
    leg_state_e state_a, state_b;

    // Fault latch: a new fault condition always beats a simultaneous clear.
    // Legs are held off in the cycle a fault appears, while it is latched
    // and while gating is disabled.
    always_comb begin
        fault_set = i_fault | illegal_a | illegal_b;
        fault_d   = fault_set | (fault_q & ~i_fault_clear);
        force_off = fault_set | fault_q | ~i_enable;
    end

    // Latched fault register.
    always_ff @(posedge i_clock) begin
        if (i_RESET) fault_q <= 1'b0;
        else         fault_q <= fault_d;
    end

    gate_leg_fsm #(.DEADTIME(DEADTIME), .MIN_ON(MIN_ON)) u_leg_a (
        .i_clock     (i_clock),
        .i_RESET     (i_RESET),
        .i_hi        (i_MOSFET[0]),
        .i_lo        (i_MOSFET[2]),
        .i_force_off (force_off),
        .o_gate_hi   (hi_a),
        .o_gate_lo   (lo_a),
        .o_state     (state_a),
        .o_illegal   (illegal_a)
    );

    gate_leg_fsm #(.DEADTIME(DEADTIME), .MIN_ON(MIN_ON)) u_leg_b (
        .i_clock     (i_clock),
        .i_RESET     (i_RESET),
        .i_hi        (i_MOSFET[1]),
        .i_lo        (i_MOSFET[3]),
        .i_force_off (force_off),
        .o_gate_hi   (hi_b),
        .o_gate_lo   (lo_b),
        .o_state     (state_b),
        .o_illegal   (illegal_b)
    );

    assign o_gate      = {lo_b, lo_a, hi_b, hi_a};
    assign o_leg_state = {state_b, state_a};
    assign o_fault     = fault_q;
    assign o_busy      = (state_a == LEG_DEAD) | (state_b == LEG_DEAD);

endmodule

// File: tb/tb_gate_deadtime_sequencer.sv
// Bench for gate_deadtime_sequencer: directed scenarios with literal
// expectations, a hybrid-control sweep and randomized traffic, all watched
// every cycle by a behavioural model and shoot-through / dead-gap monitors.
module tb_gate_deadtime_sequencer;

    localparam int DT = 10;
    localparam int MO = 20;

    logic       clk;
    logic       rst;
    logic [3:0] mos;
    logic       en;
    logic       flt;
    logic       clr;
    logic [3:0] o_gate;
    logic [3:0] o_leg_state;
    logic       o_fault;
    logic       o_busy;

    int checks   = 0;
    int failures = 0;

    gate_deadtime_sequencer dut (
        .i_clock       (clk),
        .i_RESET       (rst),
        .i_MOSFET      (mos),
        .i_enable      (en),
        .i_fault       (flt),
        .i_fault_clear (clr),
        .o_gate        (o_gate),
        .o_leg_state   (o_leg_state),
        .o_fault       (o_fault),
        .o_busy        (o_busy)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Leg phase: 0 off, 1 high conducting, 2 low conducting, 3 dead.
    // age = number of cycles spent in the current phase.
    int   m_ph[2];
    int   m_age[2];
    logic m_fault;
    bit   model_valid = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_ph[0] = 0; m_ph[1] = 0;
            m_age[0] = 0; m_age[1] = 0;
            m_fault = 1'b0;
            model_valid = 1;
        end else if (model_valid) begin
            bit want_hi, want_lo, blocked, trip;
            int nxt;
            trip    = flt || (mos[0] && mos[2]) || (mos[1] && mos[3]);
            blocked = trip || m_fault || !en;
            for (int leg = 0; leg < 2; leg++) begin
                want_hi = mos[leg];
                want_lo = mos[leg+2];
                nxt = m_ph[leg];
                if (blocked) nxt = 0;
                else if (m_ph[leg] == 0) begin
                    if (want_hi || want_lo) nxt = 3;
                end else if (m_ph[leg] == 3) begin
                    if (m_age[leg] + 1 == DT) nxt = want_hi ? 1 : (want_lo ? 2 : 0);
                end else begin
                    // Conducting: turning off is free, commutating needs MIN_ON dwell.
                    bool_dummy();
                    if (!want_hi && !want_lo) nxt = 0;
                    else if (((m_ph[leg] == 1 && want_lo) || (m_ph[leg] == 2 && want_hi))
                             && m_age[leg] + 1 >= MO) nxt = 3;
                end
                m_age[leg] = (nxt == m_ph[leg]) ? m_age[leg] + 1 : 0;
                m_ph[leg]  = nxt;
            end
            m_fault = trip || (m_fault && !clr);
        end
    end

    function automatic void bool_dummy();
    endfunction

    // ---------------- compare process and safety monitors ----------------
    int  off_run[2];
    bit  prev_on[2];

    always @(negedge clk) begin
        if (model_valid) begin
            logic [3:0] eg, es;
            eg = 4'b0;
            eg[0] = (m_ph[0] == 1); eg[2] = (m_ph[0] == 2);
            eg[1] = (m_ph[1] == 1); eg[3] = (m_ph[1] == 2);
            es = {m_ph[1][1:0], m_ph[0][1:0]};
            chk("model_gate", {28'b0, o_gate}, {28'b0, eg});
            chk("model_leg_state", {28'b0, o_leg_state}, {28'b0, es});
            chk("model_fault", {31'b0, o_fault}, {31'b0, m_fault});
            chk("model_busy", {31'b0, o_busy}, {31'b0, (m_ph[0] == 3) || (m_ph[1] == 3)});
            for (int leg = 0; leg < 2; leg++) begin
                bit hi, lo;
                hi = o_gate[leg];
                lo = o_gate[leg+2];
                if (hi && lo) chk("shoot_through", 32'd1, 32'd0);
                if (hi || lo) begin
                    if (!prev_on[leg]) chk("dead_gap_ok", {31'b0, off_run[leg] >= DT}, 32'd1);
                    off_run[leg] = 0;
                end else begin
                    off_run[leg]++;
                end
                prev_on[leg] = hi || lo;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; mos = 4'b0; en = 1'b1; flt = 1'b0; clr = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_state(input int leg, input logic [1:0] val, input int max, output int n);
        logic [1:0] st;
        n = 0;
        st = leg ? o_leg_state[3:2] : o_leg_state[1:0];
        while (st != val && n < max) begin
            tick();
            n++;
            st = leg ? o_leg_state[3:2] : o_leg_state[1:0];
        end
        if (st != val) chk("wait_state_timeout", {30'b0, st}, {30'b0, val});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int cmd_a, cmd_b, hold_a, hold_b;
        rst = 1'b1; mos = 4'b0; en = 1'b1; flt = 1'b0; clr = 1'b0;
        for (int i = 0; i < 2; i++) begin off_run[i] = 0; prev_on[i] = 0; end

        // Reset state
        do_reset();
        chk("reset_gate", {28'b0, o_gate}, 32'h0);
        chk("reset_leg_state", {28'b0, o_leg_state}, 32'h0);
        chk("reset_fault", {31'b0, o_fault}, 32'h0);
        chk("reset_busy", {31'b0, o_busy}, 32'h0);

        // Commutation latency: high for 30 cycles then low
        mos = 4'b0001;
        repeat (30) tick();
        chk("a_on_h_before_commutate", {28'b0, o_gate}, 32'h1);
        mos = 4'b0100;
        tick();
        chk("a_hi_falls_k1", {28'b0, o_gate}, 32'h0);
        chk("a_busy_k1", {31'b0, o_busy}, 32'h1);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("a_dead_gate_lo_low", {31'b0, o_gate[2]}, 32'h0);
            chk("a_dead_busy", {31'b0, o_busy}, 32'h1);
        end
        tick();
        chk("a_lo_rises_k11", {28'b0, o_gate}, 32'h4);
        chk("a_busy_done_k11", {31'b0, o_busy}, 32'h0);

        // MIN_ON hold: commutation request arrives 5 cycles into ON_H
        do_reset();
        mos = 4'b0001;
        wait_state(0, 2'b01, 40, n);
        chk("minon_entry_latency", n, 32'd11);
        repeat (5) tick();
        mos = 4'b0100;
        wait_state(0, 2'b11, 40, n);
        chk("minon_dwell_edges", 5 + n, 32'd20);
        wait_state(0, 2'b10, 40, n);
        chk("minon_dead_len", n, 32'd10);

        // Illegal pair, fault priority over clear, clear and re-entry
        do_reset();
        mos = 4'b0001;
        repeat (15) tick();
        mos = 4'b0101;
        tick();
        chk("illegal_fault", {31'b0, o_fault}, 32'h1);
        chk("illegal_gate", {28'b0, o_gate}, 32'h0);
        chk("illegal_leg_state", {28'b0, o_leg_state}, 32'h0);
        mos = 4'b0001; flt = 1'b1; clr = 1'b1;
        tick();
        chk("clear_lost_to_fault", {31'b0, o_fault}, 32'h1);
        flt = 1'b0;
        tick();
        chk("clear_ok", {31'b0, o_fault}, 32'h0);
        chk("clear_legs_off", {28'b0, o_leg_state}, 32'h0);
        clr = 1'b0;
        tick();
        chk("reentry_dead", {28'b0, o_leg_state}, 32'h3);

        // Enable drop in ON_L and re-enable with CMD_H on leg B
        do_reset();
        mos = 4'b1000;
        wait_state(1, 2'b10, 40, n);
        chk("b_on_l_gate", {28'b0, o_gate}, 32'h8);
        en = 1'b0;
        tick();
        chk("disable_b_lo_off", {31'b0, o_gate[3]}, 32'h0);
        chk("disable_b_state", {30'b0, o_leg_state[3:2]}, 32'h0);
        repeat (3) tick();
        en = 1'b1; mos = 4'b0010;
        n = 0;
        while (!o_gate[1] && n < 40) begin tick(); n++; end
        chk("reenable_b_hi_edges", n, 32'd11);

        // Reset in the middle of DEAD
        do_reset();
        mos = 4'b0001;
        tick(); tick();
        chk("pre_reset_busy", {31'b0, o_busy}, 32'h1);
        rst = 1'b1; mos = 4'b0;
        tick();
        chk("mid_dead_reset_gate", {28'b0, o_gate}, 32'h0);
        chk("mid_dead_reset_state", {28'b0, o_leg_state}, 32'h0);
        chk("mid_dead_reset_busy", {31'b0, o_busy}, 32'h0);
        rst = 1'b0;
        repeat (3) tick();
        chk("post_reset_stays_off", {28'b0, o_leg_state}, 32'h0);

        // Hybrid-control cycle: complementary commands, 40 cycles per state
        for (int r = 0; r < 3; r++) begin
            for (int s = 0; s < 4; s++) begin
                logic [1:0] b;
                b = s[1:0];
                mos = {~b[1], ~b[0], b[1], b[0]};
                repeat (40) tick();
            end
        end

        // Randomized traffic
        cmd_a = 0; cmd_b = 0; hold_a = 0; hold_b = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold_a == 0) begin cmd_a = $urandom_range(0, 2); hold_a = $urandom_range(1, 60); end
            else hold_a--;
            if (hold_b == 0) begin cmd_b = $urandom_range(0, 2); hold_b = $urandom_range(1, 60); end
            else hold_b--;
            mos = {cmd_b == 2, cmd_a == 2, cmd_b == 1, cmd_a == 1};
            if ($urandom_range(0, 199) == 0) begin mos[0] = 1'b1; mos[2] = 1'b1; end
            en  = ($urandom_range(0, 99) != 0);
            flt = ($urandom_range(0, 149) == 0);
            clr = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0; mos = 4'b0; flt = 1'b0; clr = 1'b0; en = 1'b1;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
